encrypt_function_4: RTL and testbench
=====================================

ENCRYPT_FUNCTION_4 -- requirements
Module: encrypt_function_4

Interface
REQ-001 Clk  input  1  rising-edge clock for all state.
REQ-002 Rst_n  input  1  asynchronous, active-low reset; takes effect immediately, released synchronously to Clk.
REQ-003 in_valid  input  1  plaintext request valid.
REQ-004 in_ready  output  1  block can accept a request this cycle.
REQ-005 plain  input  60  plaintext word, [59:0], bit 59 MSB.
REQ-006 tag  input  6  side-band field, carried unmodified into the packet.
REQ-007 out_valid  output  1  out_packet holds a valid encrypted packet.
REQ-008 out_ready  input  1  downstream accepts the packet this cycle.
REQ-009 out_packet  output  78  encrypted packet, declared [0:77], bit 0 MSB: [0:5] tag, [6:16] rand, [17:77] cipher (61 bits).
REQ-010 No parameters; all widths are fixed.

Function
REQ-011 Rand source: an 11-bit Fibonacci LFSR r[10:0] that shifts left every Clk cycle; new r[0] = r[10] XOR r[8]; the period is 2047; the value 0 never occurs.
REQ-012 Key: key[59:0] = {r, ~r, ~r, r, ~r, r[10:6]} built from the captured rand, MSB first. This is the pattern the decrypt_function_4 side rebuilds from packet bits [6:16].
REQ-013 Cipher = {1'b0, plain} + {1'b0, key}, 61 bits; bit 60 is the carry out; no truncation.
REQ-014 The decrypt side recovers plain exactly as cipher - key (mod 2^61).
REQ-015 FSM states: IDLE, ADD, HOLD.
REQ-016 IDLE: in_ready=1, out_valid=0. When in_valid=1 on an edge, capture plain, tag, and the current LFSR value as rand, then go to ADD.
REQ-017 ADD: compute the sum serially in four 15-bit slices, LSB slice first, one slice per cycle, using a 1-bit registered carry cleared on entry. After the 4th slice, write bit 60 from the final carry and go to HOLD.
REQ-018 Latency: with acceptance at edge N, out_valid goes high after edge N+4.
REQ-019 HOLD: out_valid=1, in_ready=0. out_packet stays stable while out_ready=0. When out_ready=1 on an edge, go to IDLE.
REQ-020 No bypass: a new request can only be accepted in IDLE, so the minimum spacing between accepts is 6 cycles.
REQ-021 in_ready=0 in ADD and HOLD. in_valid, plain, and tag are ignored while in_ready=0.
REQ-022 The LFSR free-runs in all states. A change after capture does not affect the packet in flight.
REQ-023 Inputs are sampled only on the accept edge; later changes to plain or tag do not affect the result.
REQ-024 out_packet holds its last value after the out handshake. Only out_valid qualifies it.

Reset
REQ-025 While Rst_n=0: state=IDLE, LFSR=11'h001, out_valid=0, in_ready=1, out_packet=0, carry=0, captured registers=0.
REQ-026 Reset asserted in ADD or HOLD abandons the operation. No partial packet is ever presented, and the first accept after release starts a clean operation.
REQ-027 The LFSR steps on the first Clk edge after Rst_n rises: 001, 002, 004, ..., 100, 201, ...

Verification
REQ-028 Reset, then in_valid=1 with plain=0 and tag=6'h2A held from the first post-reset cycle -> accept at the first edge with rand=11'h001; 4 edges later out_valid=1; packet tag=2A, rand=001, cipher = {0, 001, 7FE, 7FE, 001, 7FE, 5'b00000} (11-bit fields, MSB first).
REQ-029 plain=60'hFFF_FFFF_FFFF_FFFF, any rand -> cipher[60]=1 and cipher[59:0]=key-1 (the key is never 0); subtracting the key modulo 2^61 returns plain.
REQ-030 Hold out_ready=0 for 10 cycles in HOLD -> out_valid stays 1, out_packet is bit-stable, in_ready stays 0, and in_valid pulses are ignored; then out_ready=1 -> IDLE next cycle and in_ready=1.
REQ-031 Assert Rst_n=0 during the 2nd ADD cycle -> immediately out_valid=0, in_ready=1, LFSR=001; a subsequent request yields a correct packet with no stale carry.
REQ-032 1000 random plain/tag requests with random out_ready back-pressure -> every packet decrypts to its plain, tags match in order, and rand values follow the LFSR sequence at the accept cycles.

Source files
------------

// File: rtl/encrypt_function_4.sv
// Encrypts a 60-bit plaintext by adding a key expanded from a free-running 11-bit LFSR.
// The addition is done serially in four 15-bit slices; the packet is held until accepted downstream.
module encrypt_function_4 (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [59:0] plain,
    input  logic [5:0]  tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:77] out_packet
);

    typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;

    state_t      state;
    logic [10:0] lfsr;
    logic [59:0] plain_q;
    logic [59:0] key_q;
    logic [59:0] sum_q;
    logic [5:0]  tag_q;
    logic [10:0] rand_q;
    logic        carry;
    logic [1:0]  slice_cnt;
    logic [15:0] slice_sum;
    logic [59:0] key_now;

    assign key_now   = {lfsr, ~lfsr, ~lfsr, lfsr, ~lfsr, lfsr[10:6]};
    assign slice_sum = {1'b0, plain_q[14:0]} + {1'b0, key_q[14:0]} + {15'd0, carry};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lfsr <= 11'h001;
        end else begin
            lfsr <= {lfsr[9:0], lfsr[10] ^ lfsr[8]};
        end
    end

    // Operands shift down one slice per cycle; sum slices enter at the top,
    // so after four cycles sum_q[59:15] holds slices 2..0 in place.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_packet <= '0;
            plain_q    <= '0;
            key_q      <= '0;
            sum_q      <= '0;
            tag_q      <= '0;
            rand_q     <= '0;
            carry      <= 1'b0;
            slice_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        plain_q   <= plain;
                        tag_q     <= tag;
                        rand_q    <= lfsr;
                        key_q     <= key_now;
                        carry     <= 1'b0;
                        slice_cnt <= '0;
                        in_ready  <= 1'b0;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    plain_q   <= {15'd0, plain_q[59:15]};
                    key_q     <= {15'd0, key_q[59:15]};
                    sum_q     <= {slice_sum[14:0], sum_q[59:15]};
                    carry     <= slice_sum[15];
                    slice_cnt <= slice_cnt + 2'd1;
                    if (slice_cnt == 2'd3) begin
                        out_packet <= {tag_q, rand_q, slice_sum[15], slice_sum[14:0], sum_q[59:15]};
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypt_function_4.sv
// Directed and randomised checks for encrypt_function_4: latency, packet fields,
// back-pressure stability, reset abandonment and LFSR sequencing.
module tb_encrypt_function_4;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [59:0] plain = '0;
    logic [5:0]  tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [0:77] out_packet;

    int checks = 0;
    int failures = 0;

    localparam logic [59:0] K001 = 60'h003FFBFF001FFC0;

    encrypt_function_4 dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plain      (plain),
        .tag        (tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_packet (out_packet)
    );

    always #5 Clk = ~Clk;

    logic [10:0] model_lfsr;
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) model_lfsr <= 11'h001;
        else        model_lfsr <= {model_lfsr[9:0], model_lfsr[10] ^ model_lfsr[8]};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic [59:0] plain;
        logic [5:0]  tag;
        int          hold;
        logic [60:0] exp_cipher;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [59:0] key_of(input logic [10:0] r);
        return {r, ~r, ~r, r, ~r, r[10:6]};
    endfunction

    function automatic logic [5:0] f_tag(input logic [77:0] p);
        return p[77:72];
    endfunction

    function automatic logic [10:0] f_rand(input logic [77:0] p);
        return p[71:61];
    endfunction

    function automatic logic [60:0] f_cipher(input logic [77:0] p);
        return p[60:0];
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge Clk);
            lat++;
        end
    endtask

    task automatic drain;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
    endtask

    int          lat;
    logic [77:0] snap;
    logic [63:0] rnd64;
    logic [59:0] p;
    logic [5:0]  t;
    logic [10:0] exp_rand;
    logic [60:0] exp_c;

    initial begin
        vecs[0] = '{60'h000000000000000, 6'h2A, 0,  61'h003FFBFF001FFC0};
        vecs[1] = '{60'hFFFFFFFFFFFFFFF, 6'h3F, 10, 61'h1003FFBFF001FFBF};
        vecs[2] = '{60'h000000000000040, 6'h01, 1,  61'h003FFBFF0020000};
        vecs[3] = '{60'h123456789ABCDEF, 6'h05, 3,  61'h127452779ADCDAF};
        vecs[4] = '{60'hFFC00400FFE0040, 6'h11, 2,  61'h1000000000000000};

        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            Rst_n = 1'b0; out_ready = 1'b0;
            in_valid = 1'b1; plain = vecs[i].plain; tag = vecs[i].tag;
            #1;
            if (i == 0) begin
                check("rst_in_ready", 80'(in_ready), 80'd1);
                check("rst_out_valid", 80'(out_valid), 80'd0);
                check("rst_packet", 80'(out_packet), 80'd0);
            end
            @(negedge Clk);
            Rst_n = 1'b1;
            @(negedge Clk);
            check("accept_in_ready", 80'(in_ready), 80'd0);
            in_valid = 1'b0; plain = ~plain; tag = ~tag;
            wait_valid(lat);
            check("vec_latency", 80'(lat), 80'd4);
            check("vec_tag", 80'(f_tag(out_packet)), 80'(vecs[i].tag));
            check("vec_rand", 80'(f_rand(out_packet)), 80'h001);
            check("vec_cipher", 80'(f_cipher(out_packet)), 80'(vecs[i].exp_cipher));
            check("vec_decrypt", 80'(61'(f_cipher(out_packet) - {1'b0, K001})), 80'(vecs[i].plain));
            snap = out_packet;
            for (int k = 0; k < vecs[i].hold; k++) begin
                in_valid = k[0];
                @(negedge Clk);
                check("hold_valid", 80'(out_valid), 80'd1);
                check("hold_in_ready", 80'(in_ready), 80'd0);
                check("hold_stable", 80'(out_packet), 80'(snap));
            end
            drain();
            check("release_in_ready", 80'(in_ready), 80'd1);
            check("release_valid", 80'(out_valid), 80'd0);
            check("release_packet_kept", 80'(out_packet), 80'(snap));
        end

        // Reset during the second ADD cycle of a carry-heavy operation.
        @(negedge Clk);
        Rst_n = 1'b0;
        in_valid = 1'b1; plain = 60'hFFC00400FFE0040; tag = 6'h01;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("midrst_valid", 80'(out_valid), 80'd0);
        check("midrst_in_ready", 80'(in_ready), 80'd1);
        check("midrst_packet", 80'(out_packet), 80'd0);
        in_valid = 1'b1; plain = '0; tag = 6'h15;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check("midrst_latency", 80'(lat), 80'd4);
        check("midrst_tag", 80'(f_tag(out_packet)), 80'h15);
        check("midrst_rand", 80'(f_rand(out_packet)), 80'h001);
        check("midrst_cipher", 80'(f_cipher(out_packet)), 80'({1'b0, K001}));
        drain();

        // Idle nine edges after release: LFSR goes 001..100, then 201.
        @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (9) @(negedge Clk);
        in_valid = 1'b1; plain = '0; tag = 6'h03;
        @(negedge Clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check("lfsr_latency", 80'(lat), 80'd4);
        check("lfsr_rand", 80'(f_rand(out_packet)), 80'h201);
        check("lfsr_cipher", 80'(f_cipher(out_packet)), 80'({1'b0, key_of(11'h201)}));
        drain();

        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            check("rnd_in_ready", 80'(in_ready), 80'd1);
            rnd64 = {$urandom(), $urandom()};
            p = rnd64[59:0];
            t = 6'($urandom_range(0, 63));
            exp_rand = model_lfsr;
            exp_c = {1'b0, p} + {1'b0, key_of(exp_rand)};
            in_valid = 1'b1; plain = p; tag = t;
            @(negedge Clk);
            in_valid = 1'b0; plain = ~p;
            wait_valid(lat);
            check("rnd_latency", 80'(lat), 80'd4);
            check("rnd_tag", 80'(f_tag(out_packet)), 80'(t));
            check("rnd_rand", 80'(f_rand(out_packet)), 80'(exp_rand));
            check("rnd_cipher", 80'(f_cipher(out_packet)), 80'(exp_c));
            check("rnd_decrypt", 80'(61'(f_cipher(out_packet) - {1'b0, key_of(exp_rand)})), 80'(p));
            snap = out_packet;
            repeat ($urandom_range(0, 3)) begin
                @(negedge Clk);
                check("rnd_hold", 80'(out_packet), 80'(snap));
            end
            drain();
            check("rnd_done", 80'(out_valid), 80'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
